// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end that owns the fetch PC, issues
//   in-order requests to a variable-latency instruction memory and queues
//   returned instructions with their PCs for decode.
// Latency: a response captured at edge N shows up as inst_valid in the cycle
//   after edge N. There is no zero-cycle bypass from imem_rdata to inst.
// Backpressure: imem_req drops while allocated entries plus pending discards
//   fill all DEPTH slots. inst is held while inst_valid=1 and inst_ready=0.
// Ports:
//   clk, rst                    clock and async active-high reset
//   imem_req/addr/ready         request channel; addr is the fetch PC
//   imem_rvalid/rdata           in-order response channel
//   redirect_valid/pc           branch/jump redirect; flushes the queue
//   inst_valid/inst/inst_pc     head of queue to decode
//   inst_ready                  decode consumes head
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]   head_q, tail_q, fill_q;
  // count_q: allocated entries; unfilled_q: allocated but awaiting data;
  // discard_q: responses still owed by memory for flushed requests.
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   unfilled_q, unfilled_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW:0]     occ_sum;
  logic            accept, fill, pop;

  assign occ_sum   = {1'b0, count_q} + {1'b0, discard_q};
  // rst gate keeps the request low while reset is held.
  assign imem_req  = !rst && !redirect_valid && (occ_sum < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign inst_valid = (count_q != '0) && filled_q[head_q] && !redirect_valid;
  assign inst       = inst_q[head_q];
  assign inst_pc    = pc_q[head_q];

  assign accept = imem_req && imem_ready;
  // While debts remain, or during a redirect, the response belongs to a
  // flushed request and is dropped.
  assign fill   = imem_rvalid && (discard_q == '0) && !redirect_valid;
  assign pop    = inst_valid && inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      count_d    = '0;
      unfilled_d = '0;
      // Every outstanding request becomes a debt, less the one paid now.
      discard_d  = unfilled_q + discard_q - CW'(imem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
      count_d    = count_q + CW'(accept) - CW'(pop);
      unfilled_d = unfilled_q + CW'(accept) - CW'(fill);
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      unfilled_q <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      filled_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      discard_q  <= discard_d;
      if (redirect_valid) begin
        head_q   <= '0;
        tail_q   <= '0;
        fill_q   <= '0;
        filled_q <= '0;
      end else begin
        // Tail, fill and head slots are distinct whenever more than one
        // of these fires, so the per-bit updates never collide.
        if (accept) begin
          pc_q[tail_q]     <= fetch_pc_q;
          filled_q[tail_q] <= 1'b0;
          tail_q           <= tail_q + 1'b1;
        end
        if (fill) begin
          inst_q[fill_q]   <= imem_rdata;
          filled_q[fill_q] <= 1'b1;
          fill_q           <= fill_q + 1'b1;
        end
        if (pop) begin
          filled_q[head_q] <= 1'b0;
          head_q           <= head_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model
//   and a scoreboard of expected (pc, inst) pairs.
// One stimulus step per clock: inputs driven after the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] inflight[$];  // addresses the memory still owes a response for
  logic [31:0] exp_q[$];     // PCs decode should still receive, in order
  int          checks = 0;
  int          failures = 0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  logic        last_req, last_valid;
  logic [31:0] last_addr, exp_pc, first_pc;
  bit          cap_first = 0;

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, observe settled outputs, update model, clock.
  task automatic cycle(input logic mrdy, input logic irdy, input logic rv_en,
                       input logic redir, input logic [31:0] rpc);
    logic acc, pp;
    imem_ready     = mrdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rvalid    = rv_en && (inflight.size() > 0);
    imem_rdata     = imem_rvalid ? mk(inflight[0]) : 32'h0;
    #1;
    last_req   = imem_req;
    last_addr  = imem_addr;
    last_valid = inst_valid;
    acc = imem_req && imem_ready;
    pp  = inst_valid && inst_ready;
    if (pp) begin
      pop_cnt++;
      chk("pop_has_expect", {31'b0, exp_q.size() > 0}, 32'h1);
      if (exp_q.size() > 0) begin
        chk("inst_pc", inst_pc, exp_q[0]);
        chk("inst", inst, mk(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (cap_first) begin
        first_pc  = inst_pc;
        cap_first = 0;
      end
    end
    if (imem_rvalid) void'(inflight.pop_front());
    if (redir) begin
      chk("redir_no_valid", {31'b0, inst_valid}, 32'h0);
      chk("redir_no_req", {31'b0, imem_req}, 32'h0);
      exp_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end
    if (acc) begin
      acc_cnt++;
      chk("imem_addr", imem_addr, exp_pc);
      exp_pc = exp_pc + 32'd4;
      inflight.push_back(imem_addr);
      exp_q.push_back(imem_addr);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_ready = 0; inst_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    inflight.delete();
    exp_q.delete();
    exp_pc = 32'h0;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (inflight.size() == 0 && exp_q.size() == 0) break;
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("drain_empty", 32'(exp_q.size() + inflight.size()), 32'h0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    exp_pc = 32'h0;
    @(negedge clk);
    #1;
    // Reset state
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Stream: one instruction per cycle once the pipe is primed
    acc_cnt = 0; pop_cnt = 0;
    cycle(1, 1, 1, 0, 0);
    chk("first_req", {31'b0, last_req}, 32'h1);
    chk("first_addr", last_addr, 32'h0);
    for (int i = 0; i < 11; i++) cycle(1, 1, 1, 0, 0);
    chk("stream_accepts", 32'(acc_cnt), 32'd12);
    chk("stream_pops", 32'(pop_cnt), 32'd10);
    drain();

    // Full backpressure
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0, 0);
    chk("full_accepts", 32'(acc_cnt), 32'd4);
    chk("full_no_req", {31'b0, last_req}, 32'h0);
    chk("full_head_valid", {31'b0, last_valid}, 32'h1);
    cycle(1, 1, 1, 0, 0);
    chk("full_pop_cycle_req", {31'b0, last_req}, 32'h0);
    cycle(1, 1, 1, 0, 0);
    chk("after_pop_req", {31'b0, last_req}, 32'h1);
    chk("after_pop_addr", last_addr, 32'h10);
    drain();

    // Memory stall
    do_reset();
    cycle(1, 1, 1, 0, 0);
    pop_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 0, 0);
      chk("stall_req", {31'b0, last_req}, 32'h1);
      chk("stall_addr", last_addr, 32'h4);
    end
    chk("stall_pops", 32'(pop_cnt), 32'd1);
    cycle(1, 1, 1, 0, 0);
    drain();

    // Redirect with two requests in flight
    do_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 1, 32'h103);
    cap_first = 1; first_pc = 32'hDEAD_BEEF; pop_cnt = 0;
    cycle(1, 1, 1, 0, 0);
    chk("redir_addr", last_addr, 32'h100);
    chk("redir_req", {31'b0, last_req}, 32'h1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0);
    chk("redir_first_pc", first_pc, 32'h100);
    chk("redir_pops", 32'(pop_cnt), 32'd3);
    drain();

    // Redirect coinciding with a response and inst_ready
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h200);
    chk("coinc_discard", {29'b0, dut.discard_q}, 32'(inflight.size()));
    chk("coinc_discard_val", {29'b0, dut.discard_q}, 32'd1);
    cap_first = 1; first_pc = 32'hDEAD_BEEF;
    cycle(1, 1, 1, 0, 0);
    chk("coinc_addr", last_addr, 32'h200);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0);
    chk("coinc_first_pc", first_pc, 32'h200);
    drain();

    // Reset asserted mid-stream with three entries queued
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0);
    idle_inputs();
    #1;
    chk("pre_rst_valid", {31'b0, inst_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    chk("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    inflight.delete();
    exp_q.delete();
    exp_pc = 32'h0;
    rst = 1'b0;
    cycle(1, 1, 1, 0, 0);
    chk("post_rst_req", {31'b0, last_req}, 32'h1);
    chk("post_rst_addr", last_addr, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
